segre_main_memory: RTL and testbench
====================================

# segre_main_memory

Line-granular main-memory model and controller sitting directly downstream of the core's shared memory port, behind the instruction/data cache refill and writeback path. It accepts one cache-line read or write request at a time, holds it for a fixed programmable latency, then commits the write or returns the line with a one-cycle ready pulse. It gives the core's controller FSM a deterministic multi-cycle memory so that cache miss, refill and writeback sequencing can be exercised.

## Interface

- LINE_BYTES, 16, bytes per cache line; power of two, ≥4
- ADDR_W, 32, request address width
- MEM_LINES, 4096, number of stored lines; power of two
- LATENCY, 5, cycles spent in BUSY per request; ≥1
- clk_i  in  1  clock; all state updates on the rising edge
- rsn_i  in  1  reset; asynchronous, active-low
- rd_i  in  1  line read request, level, held by requester until ready_o
- wr_i  in  1  line write request, level, held by requester until ready_o
- addr_i  in  ADDR_W  byte address of the request
- wr_data_i  in  LINE_BYTES×8  line to write; byte 0 = lowest address
- rd_data_o  out  LINE_BYTES×8  line returned by the last completed request
- ready_o  out  1  one-cycle completion pulse
- busy_o  out  1  high whenever state ≠ IDLE

## Operation

- States: IDLE, BUSY, RESP, GAP.
- IDLE: if rd_i|wr_i, latch the op, line index and wr_data_i, load the counter with LATENCY-1, go to BUSY. Otherwise stay.
- Op decode: wr_i=1 means write, regardless of rd_i. rd_i=1 with wr_i=0 means read.
- Line index is addr_i[OFF+log2(MEM_LINES)-1:OFF] with OFF=log2(LINE_BYTES). Offset bits below OFF are ignored. Upper bits above the index field are ignored, so addresses wrap modulo MEM_LINES lines.
- BUSY: inputs ignored. If counter≠0, decrement it. If counter==0, go to RESP.
  - On that same edge, a write stores the latched data into the array and also loads it into rd_data_o.
  - On that same edge, a read loads the array line into rd_data_o.
- RESP: ready_o=1 for exactly this cycle, then go to GAP.
- GAP: one cycle with inputs ignored, so the requester can deassert its level request after seeing ready. Then go to IDLE.
- rd_data_o holds its value until the next completion.
- The array is not reset. Its contents after power-up are undefined.
- Reset, at any time and in any state:
  - state returns to IDLE; ready_o and busy_o go to 0; rd_data_o goes to 0; counter clears.
  - An in-flight request is aborted and its write is not committed.
  - Array contents written before the reset are preserved.

## Timing

- Reset values: ready_o=0, busy_o=0, rd_data_o=0, state=IDLE.
- Request first high in cycle c while state is IDLE:
  - busy_o=1 from cycle c+1.
  - ready_o=1 in cycle c+LATENCY+1 only.
  - GAP in cycle c+LATENCY+2.
  - IDLE in cycle c+LATENCY+3, where a new request may be accepted.
- Minimum request-to-request period is LATENCY+3 cycles.
- A write is visible to a read accepted in any later cycle.
- A request raised while busy_o=1 is not latched. It is accepted only once the block is back in IDLE, and only if still held.
- A request that drops before acceptance is never serviced.
- Requests and data are sampled only at the IDLE accept edge. Changes to addr_i or wr_data_i during BUSY have no effect.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- Reset, then write line 0xA5A5…(16 bytes) at addr 0x100, then read addr 0x100 (LATENCY=5):
  - ready_o pulses 6 cycles after each accept;
  - the read returns 0xA5A5….
- Unaligned access: write at 0x104, read at 0x10C → same line; data matches the write.
- Wrap-around: write pattern P to 0x0, then write Q to addr MEM_LINES×LINE_BYTES (0x10000):
  - reading 0x0 returns Q.
- Held request: requester holds rd_i through the ready pulse and drops it one cycle later → exactly one ready_o pulse and no second request.
  - Back-to-back requests: accept-edge spacing is 8 cycles.
- rd_i and wr_i high together with data D at 0x200 → treated as a write.
  - The ready cycle's rd_data_o equals D.
  - A later read of 0x200 returns D.
- Reset mid-operation: pull rsn_i low during BUSY of a write of X to 0x300, whose line previously held Y.
  - Outputs go to 0 immediately (asynchronously).
  - After release, a read of 0x300 returns Y.

Source files
------------

// File: rtl/segre_main_memory.sv
// Line-granular main memory with a fixed programmable service latency.
// One request at a time: IDLE -> BUSY (LATENCY cycles) -> RESP (ready pulse) -> GAP -> IDLE.
module segre_main_memory #(
    parameter int LINE_BYTES = 16,
    parameter int ADDR_W     = 32,
    parameter int MEM_LINES  = 4096,
    parameter int LATENCY    = 5
) (
    input  logic                    clk_i,
    input  logic                    rsn_i,
    input  logic                    rd_i,
    input  logic                    wr_i,
    input  logic [ADDR_W-1:0]       addr_i,
    input  logic [LINE_BYTES*8-1:0] wr_data_i,
    output logic [LINE_BYTES*8-1:0] rd_data_o,
    output logic                    ready_o,
    output logic                    busy_o
);

    localparam int OFF    = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(MEM_LINES);
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int LINE_W = LINE_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        GAP  = 2'd3
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               op_wr_q;
    logic [IDX_W-1:0]   idx_q;
    logic [LINE_W-1:0]  wdata_q;
    logic [LINE_W-1:0]  rd_data_q;
    logic               ready_q;
    logic               busy_q;

    logic [LINE_W-1:0]  mem_q [MEM_LINES];

    logic [IDX_W-1:0]   idx_d;
    logic               commit_wr;
    logic               unused_addr;

    // Offset bits and anything above the index field fall away, so addresses wrap.
    assign idx_d       = addr_i[OFF+IDX_W-1:OFF];
    assign unused_addr = ^{addr_i[ADDR_W-1:OFF+IDX_W], addr_i[OFF-1:0]};

    assign commit_wr = (state_q == BUSY) && (cnt_q == '0) && op_wr_q;

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_wr_q   <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rd_i || wr_i) begin
                        op_wr_q <= wr_i;
                        idx_q   <= idx_d;
                        wdata_q <= wr_data_i;
                        cnt_q   <= CNT_W'(LATENCY - 1);
                        state_q <= BUSY;
                        busy_q  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q   <= RESP;
                        ready_q   <= 1'b1;
                        rd_data_q <= op_wr_q ? wdata_q : mem_q[idx_q];
                    end
                end
                RESP: begin
                    state_q <= GAP;
                end
                GAP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Array has no reset so its contents survive rsn_i; an aborted write never reaches here
    // because reset forces the FSM out of BUSY.
    always_ff @(posedge clk_i) begin
        if (commit_wr) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign rd_data_o = rd_data_q;
    assign ready_o   = ready_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_segre_main_memory.sv
// Directed bench for segre_main_memory: a vector table of line requests plus
// hand sequences for held requests, back-to-back requests and mid-operation reset.
module tb_segre_main_memory;

    localparam int LINE_BYTES = 16;
    localparam int ADDR_W     = 32;
    localparam int MEM_LINES  = 4096;
    localparam int LATENCY    = 5;
    localparam int LW         = LINE_BYTES * 8;

    logic              clk;
    logic              rsn_i;
    logic              rd_i;
    logic              wr_i;
    logic [ADDR_W-1:0] addr_i;
    logic [LW-1:0]     wr_data_i;
    logic [LW-1:0]     rd_data_o;
    logic              ready_o;
    logic              busy_o;

    int pass_cnt = 0;
    int total    = 0;

    segre_main_memory #(
        .LINE_BYTES (LINE_BYTES),
        .ADDR_W     (ADDR_W),
        .MEM_LINES  (MEM_LINES),
        .LATENCY    (LATENCY)
    ) dut (
        .clk_i     (clk),
        .rsn_i     (rsn_i),
        .rd_i      (rd_i),
        .wr_i      (wr_i),
        .addr_i    (addr_i),
        .wr_data_i (wr_data_i),
        .rd_data_o (rd_data_o),
        .ready_o   (ready_o),
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic          rd;
        logic          wr;
        logic [31:0]   addr;
        logic [LW-1:0] data;
        logic [LW-1:0] exp;
        string         name;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Raise a request, hold it until ready, scramble addr/data during BUSY,
    // and check latency, returned line and the BUSY/GAP/IDLE sequence.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [LW-1:0] d, input logic [LW-1:0] exp, input string nm);
        int  n;
        bit  seen;
        @(negedge clk);
        rd_i = rd; wr_i = wr; addr_i = a; wr_data_i = d;
        seen = 0; n = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check({nm, " busy_after_accept"}, LW'(busy_o), LW'(1));
                addr_i    = a ^ 32'h40;
                wr_data_i = ~d;
            end
            if (ready_o) begin
                seen = 1;
                check({nm, " latency"}, LW'(n), LW'(LATENCY + 1));
                check({nm, " data"}, rd_data_o, exp);
                rd_i = 1'b0; wr_i = 1'b0;
            end
        end
        if (!seen) check({nm, " ready_timeout"}, LW'(0), LW'(1));
        @(negedge clk);
        check({nm, " gap_ready_low"}, LW'(ready_o), LW'(0));
        check({nm, " gap_busy_high"}, LW'(busy_o), LW'(1));
        @(negedge clk);
        check({nm, " idle_busy_low"}, LW'(busy_o), LW'(0));
    endtask

    localparam logic [LW-1:0] A5 = {16{8'hA5}};
    localparam logic [LW-1:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [LW-1:0] P  = {4{32'h1234_5678}};
    localparam logic [LW-1:0] Q  = {4{32'hCAFE_F00D}};
    localparam logic [LW-1:0] D  = {4{32'h0BAD_BEEF}};
    localparam logic [LW-1:0] Y  = {8{16'h5A3C}};
    localparam logic [LW-1:0] X  = {16{8'h77}};

    initial begin
        int pulses;
        int n1;
        int n2;

        vecs[0]  = '{1'b0, 1'b1, 32'h100,   A5, A5, "wr_100"};
        vecs[1]  = '{1'b1, 1'b0, 32'h100,   '0, A5, "rd_100"};
        vecs[2]  = '{1'b0, 1'b1, 32'h104,   D1, D1, "wr_104"};
        vecs[3]  = '{1'b1, 1'b0, 32'h10C,   '0, D1, "rd_10C"};
        vecs[4]  = '{1'b0, 1'b1, 32'h0,     P,  P,  "wr_0_P"};
        vecs[5]  = '{1'b0, 1'b1, 32'h10000, Q,  Q,  "wr_10000_Q"};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,     '0, Q,  "rd_0_wrap"};
        vecs[7]  = '{1'b1, 1'b1, 32'h200,   D,  D,  "rdwr_200"};
        vecs[8]  = '{1'b1, 1'b0, 32'h200,   '0, D,  "rd_200"};
        vecs[9]  = '{1'b0, 1'b1, 32'h300,   Y,  Y,  "wr_300_Y"};
        vecs[10] = '{1'b1, 1'b0, 32'h104,   '0, D1, "rd_104"};

        rsn_i = 1'b0; rd_i = 1'b0; wr_i = 1'b0; addr_i = '0; wr_data_i = '0;
        repeat (2) @(negedge clk);
        check("reset ready", LW'(ready_o), LW'(0));
        check("reset busy", LW'(busy_o), LW'(0));
        check("reset rd_data", rd_data_o, '0);
        rsn_i = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++)
            do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp, vecs[i].name);

        // Held request: rd_i stays high through ready, drops in GAP -> single pulse.
        @(negedge clk);
        rd_i = 1'b1; addr_i = 32'h200;
        pulses = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ready_o) begin
                pulses++;
                check("held data", rd_data_o, D);
            end
            if (n == LATENCY + 2) rd_i = 1'b0;
        end
        check("held pulses", LW'(pulses), LW'(1));
        check("held idle", LW'(busy_o), LW'(0));

        // Back-to-back: rd_i held continuously, two services 8 cycles apart.
        @(negedge clk);
        rd_i = 1'b1; addr_i = 32'h10C;
        pulses = 0; n1 = 0; n2 = 0;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (ready_o) begin
                pulses++;
                if (pulses == 1) n1 = n;
                else begin
                    n2 = n;
                    rd_i = 1'b0;
                end
                check("b2b data", rd_data_o, D1);
            end
        end
        check("b2b pulses", LW'(pulses), LW'(2));
        check("b2b first", LW'(n1), LW'(LATENCY + 1));
        check("b2b spacing", LW'(n2 - n1), LW'(LATENCY + 3));

        // Reset during BUSY of a write of X over Y at 0x300.
        @(negedge clk);
        wr_i = 1'b1; addr_i = 32'h300; wr_data_i = X;
        repeat (3) @(negedge clk);
        check("mid busy before reset", LW'(busy_o), LW'(1));
        check("rd_data before reset", rd_data_o, D1);
        #2 rsn_i = 1'b0;
        #1;
        check("async reset busy", LW'(busy_o), LW'(0));
        check("async reset ready", LW'(ready_o), LW'(0));
        check("async reset rd_data", rd_data_o, '0);
        @(negedge clk);
        wr_i = 1'b0;
        repeat (2) @(negedge clk);
        rsn_i = 1'b1;
        @(negedge clk);
        check("post reset idle", LW'(busy_o), LW'(0));
        do_req(1'b1, 1'b0, 32'h300, '0, Y, "rd_300_after_reset");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
